demultiplexer2to8: RTL
======================

# demultiplexer2to8

Buffered 1-to-8 demultiplexer: the write-side counterpart of the 8-input 16-bit multiplexer. It routes one 16-bit word per accepted transfer to one of eight output channels selected by a 3-bit select. Each channel holds its word in a one-entry buffer until the consumer accepts it over valid/ready. It sits between the datapath result bus and the eight register/unit write ports of the processor.

## Interface
Parameters:
- WIDTH, 16, data word width
- N, 8, number of output channels (fixed at 8 for this revision)
- SEL_W, 3, select width, log2(N)

Ports:
- clk  input  1  rising-edge clock; sole clock domain
- rst  input  1  synchronous, active-high reset
- in_data  input  WIDTH  word to route
- in_sel  input  SEL_W  destination channel index 0..7
- in_valid  input  1  producer presents a word
- in_ready  output  1  demux can accept into channel in_sel this cycle
- out_data  output  N*WIDTH  flat bus; channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  N  channel k holds a word
- out_ready  input  N  consumer k accepts its word
- occ  output  4  number of channels with out_valid=1, 0..8
- in_bcast  input  1  broadcast request; present only when DEMUX_BROADCAST_EN is defined

## Operation
- Accept: in_valid && in_ready. The word loads into slot in_sel; other slots are untouched.
- in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]). A full slot accepts only if it drains in the same cycle.
- Drain: out_valid[k] && out_ready[k] empties slot k unless a load into k happens the same cycle.
- Same-cycle drain and load on slot k: out_valid[k] stays 1 and out_data[k] takes the new word. No bubble, no loss.
- Loads never occur when in_ready=0. In that case in_data is ignored and the producer holds it.
- out_data[k] holds its value after drain; the value is don't-care while out_valid[k]=0 but is not cleared.
- occ is a register updated each cycle to popcount(next out_valid). Width rule: 4 bits cover 0..8 with no wrap.
- in_sel is always in range 0..7 because all codes are legal, so there is no error path.
- Reset: out_valid=0, out_data=0, occ=0, in_ready=0 while rst=1.
- Reset asserted mid-transfer discards all buffered words. A word presented during reset is not accepted.

## Timing
- Latency: accepted at edge t; visible on out_valid/out_data after edge t (cycle t+1).
- Throughput: one word per cycle to any channel, including back-to-back to the same channel while its consumer keeps out_ready=1.
- in_ready is combinational from in_sel, out_valid and out_ready[in_sel]. It must not depend on in_valid.
- out_valid, out_data and occ are registered outputs.
- Consumers keep out_ready independent of out_valid (standard valid/ready).

## Configuration
- DEMUX_BROADCAST_EN defined:
  - in_bcast port exists.
  - When in_bcast=1, in_ready = AND over k of (!out_valid[k] || out_ready[k]).
  - An accept loads in_data into all 8 slots and occ becomes 8; in_sel is ignored.
  - When in_bcast=0, behaviour is unchanged.
- DEMUX_BROADCAST_EN undefined: in_bcast port is absent and the logic is not generated. Behaviour is exactly the unicast behaviour above.

## Structure
- Package demux_pkg holds the WIDTH, N and SEL_W constants, shared with the multiplexer and the register-file top.
- Sub-module demux_slot is the one-entry buffer. Inputs: clk, rst, load, d, drain_ready. Outputs: q, valid, can_accept. It is instantiated N times via generate.
- The top level contains the select decode, the in_ready mux, the occ popcount and the optional broadcast logic.

## Test plan
- Reset then single write: in_sel=5, in_data=16'hBEEF, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=8'b0010_0000, channel 5 data=16'hBEEF, occ=1.
- Backpressure on a full slot: channel 5 full, out_ready=0, present in_sel=5, 16'h1234 -> in_ready=0 and channel 5 still 16'hBEEF. Then out_ready[5]=1 -> in_ready=1 the same cycle, 16'h1234 loads, out_valid[5] stays 1, occ stays 1.
- Fill all channels: sel 0..7 with data 16'h0000..16'h0007 on consecutive cycles, out_ready=0 -> out_valid=8'hFF, occ=8, and each channel k holds k.
- Independent drain: with all channels full, pulse out_ready=8'b1000_0001 for one cycle -> out_valid=8'h7E, occ=6, and in_ready=1 only for in_sel of 0 or 7.
- Reset mid-operation: with 3 channels full, assert rst for 1 cycle while in_valid=1 -> out_valid=0, out_data=0, occ=0, and nothing is accepted during reset.
- DEMUX_BROADCAST_EN: all empty, in_bcast=1, in_data=16'hA5A5 -> all 8 channels hold 16'hA5A5 and occ=8. With channel 2 full and out_ready[2]=0, a broadcast gives in_ready=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 8-channel mux/demux pair and the register-file top.
// Also holds the channel-occupancy popcount helper.
package demux_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned N     = 8;
    localparam int unsigned SEL_W = 3;

    function automatic logic [3:0] popcount8(input logic [N-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel (valid/ready consumer side).
// A load takes priority over a drain, so a same-cycle drain+load keeps valid high.
module demux_slot #(
    parameter int unsigned WIDTH = demux_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             drain_ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             can_accept
);

    assign can_accept = !valid || drain_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (valid && drain_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demultiplexer2to8.sv
// Buffered 1-to-8 demultiplexer: routes one word per accept into a per-channel buffer.
// Optional broadcast-to-all-channels support is enabled with DEMUX_BROADCAST_EN.
module demultiplexer2to8
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = demux_pkg::WIDTH,
    parameter int unsigned N     = demux_pkg::N,
    parameter int unsigned SEL_W = demux_pkg::SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
`ifdef DEMUX_BROADCAST_EN
    input  logic               in_bcast,
`endif
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [3:0]         occ
);

    logic [N-1:0] can_accept;
    logic [N-1:0] target;
    logic [N-1:0] load;
    logic [N-1:0] nxt_valid;
    logic         accept;

    always_comb begin
        target   = '0;
        in_ready = 1'b0;
`ifdef DEMUX_BROADCAST_EN
        if (in_bcast) begin
            target   = '1;
            in_ready = !rst && (&can_accept);
        end else begin
            target[in_sel] = 1'b1;
            in_ready       = !rst && can_accept[in_sel];
        end
`else
        target[in_sel] = 1'b1;
        in_ready       = !rst && can_accept[in_sel];
`endif
    end

    assign accept = in_valid && in_ready;
    assign load   = target & {N{accept}};

    // Mirrors the slot update rule so occ tracks the registered out_valid exactly.
    assign nxt_valid = load | (out_valid & ~out_ready);

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .load       (load[k]),
            .d          (in_data),
            .drain_ready(out_ready[k]),
            .q          (out_data[k*WIDTH +: WIDTH]),
            .valid      (out_valid[k]),
            .can_accept (can_accept[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else begin
            occ <= popcount8(nxt_valid);
        end
    end

endmodule
